// File: rtl/scu_imm_pkg.sv
// Shared definitions for the SCU immediate-generator stage.
//   imm_fmt_t  : immediate format code carried on in_fmt
//   buf_cnt_t  : occupancy of the two-entry output buffer
//   DEF_*      : default field geometry for the SCU instruction encoding
package scu_imm_pkg;

    typedef enum logic [1:0] {
        FMT_SHORT = 2'd0,
        FMT_LONG  = 2'd1,
        FMT_UPPER = 2'd2,
        FMT_RSVD  = 2'd3
    } imm_fmt_t;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } buf_cnt_t;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_ILEN      = 32;
    localparam int DEF_SHORT_LSB = 10;
    localparam int DEF_SHORT_W   = 6;
    localparam int DEF_LONG_LSB  = 10;
    localparam int DEF_LONG_W    = 12;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Bundle of the immediate-generator stage handshake and data signals.
//   slave  : view of the stage itself (consumes in_*, produces out_*)
//   master : view of the environment driving the stage
//   flush       : drop every buffered entry
//   in_*        : instruction, format, zext with valid/ready
//   out_*       : immediate, instruction and error flag with valid/ready
interface imm_gen_stage_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] in_instr;
    logic [1:0]      in_fmt;
    logic            in_zext;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [ILEN-1:0] out_instr;
    logic            out_err;

    modport slave (
        input  flush, in_valid, in_instr, in_fmt, in_zext, out_ready,
        output in_ready, out_valid, out_imm, out_instr, out_err
    );

    modport master (
        output flush, in_valid, in_instr, in_fmt, in_zext, out_ready,
        input  in_ready, out_valid, out_imm, out_instr, out_err
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction and extension.
//   instr : instruction word
//   fmt   : format code (imm_fmt_t encoding)
//   zext  : 1 = zero-extend, 0 = sign-extend (UPPER ignores it)
//   imm   : immediate extended to the full XLEN
//   err   : reserved format code presented (imm forced to 0)
module imm_extract
    import scu_imm_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int ILEN      = DEF_ILEN,
    parameter int SHORT_LSB = DEF_SHORT_LSB,
    parameter int SHORT_W   = DEF_SHORT_W,
    parameter int LONG_LSB  = DEF_LONG_LSB,
    parameter int LONG_W    = DEF_LONG_W
) (
    input  logic [ILEN-1:0] instr,
    input  logic [1:0]      fmt,
    input  logic            zext,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    if (SHORT_W < 1 || LONG_W < 1 || SHORT_W > XLEN || LONG_W > XLEN ||
        SHORT_LSB + SHORT_W > ILEN || LONG_LSB + LONG_W > ILEN) begin : g_bad_params
        $fatal(1, "imm_extract: field geometry does not fit XLEN/ILEN");
    end

    logic [SHORT_W-1:0] short_field;
    logic [LONG_W-1:0]  long_field;
    logic               short_fill;
    logic               long_fill;
    logic [XLEN-1:0]    short_ext;
    logic [XLEN-1:0]    long_ext;
    logic [XLEN-1:0]    upper_ext;
    logic               unused_instr_bits;

    assign short_field = instr[SHORT_LSB +: SHORT_W];
    assign long_field  = instr[LONG_LSB +: LONG_W];
    assign short_fill  = ~zext & short_field[SHORT_W-1];
    assign long_fill   = ~zext & long_field[LONG_W-1];
    // Opcode and register bits outside the immediate fields are not needed here.
    assign unused_instr_bits = ^instr;

    // Per-bit construction keeps every width legal even when a field spans the
    // whole XLEN (a zero-count replication would otherwise be needed).
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_bit
            if (gi < SHORT_W) begin : g_short_field
                assign short_ext[gi] = short_field[gi];
            end else begin : g_short_fill
                assign short_ext[gi] = short_fill;
            end
            if (gi < LONG_W) begin : g_long_field
                assign long_ext[gi] = long_field[gi];
            end else begin : g_long_fill
                assign long_ext[gi] = long_fill;
            end
            if (gi >= XLEN - LONG_W) begin : g_upper_field
                assign upper_ext[gi] = long_field[gi-(XLEN-LONG_W)];
            end else begin : g_upper_zero
                assign upper_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        imm = '0;
        err = 1'b0;
        case (imm_fmt_t'(fmt))
            FMT_SHORT: imm = short_ext;
            FMT_LONG:  imm = long_ext;
            FMT_UPPER: imm = upper_ext;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator with a two-entry skid buffer.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : imm_gen_stage_if.slave (flush, in_* handshake, out_* handshake)
// The immediate is finished on the input side, so the buffer only stores
// completed {imm, instr, err} entries. The main register always holds the
// oldest entry and drives out_*; the skid register holds the second.
module imm_gen_stage
    import scu_imm_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int ILEN      = DEF_ILEN,
    parameter int SHORT_LSB = DEF_SHORT_LSB,
    parameter int SHORT_W   = DEF_SHORT_W,
    parameter int LONG_LSB  = DEF_LONG_LSB,
    parameter int LONG_W    = DEF_LONG_W
) (
    input  logic            clk,
    input  logic            rst,
    imm_gen_stage_if.slave  bus
);

    logic [XLEN-1:0] x_imm;
    logic            x_err;

    imm_extract #(
        .XLEN(XLEN), .ILEN(ILEN),
        .SHORT_LSB(SHORT_LSB), .SHORT_W(SHORT_W),
        .LONG_LSB(LONG_LSB), .LONG_W(LONG_W)
    ) u_extract (
        .instr (bus.in_instr),
        .fmt   (bus.in_fmt),
        .zext  (bus.in_zext),
        .imm   (x_imm),
        .err   (x_err)
    );

    buf_cnt_t        cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [ILEN-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
    logic            main_err_q, main_err_d, skid_err_q, skid_err_d;
    logic            push, pop;

    // in_ready_q mirrors (cnt_q != CNT_FULL), so using it here keeps the
    // accept decision free of any path from out_ready.
    assign push = bus.in_valid & in_ready_q;
    assign pop  = (cnt_q != CNT_EMPTY) & bus.out_ready;

    always_comb begin
        cnt_d        = cnt_q;
        main_imm_d   = main_imm_q;
        main_instr_d = main_instr_q;
        main_err_d   = main_err_q;
        skid_imm_d   = skid_imm_q;
        skid_instr_d = skid_instr_q;
        skid_err_d   = skid_err_q;
        if (bus.flush) begin
            // Data registers keep their contents so out_* hold their last value.
            cnt_d = CNT_EMPTY;
        end else begin
            case (cnt_q)
                CNT_EMPTY: begin
                    if (push) begin
                        main_imm_d   = x_imm;
                        main_instr_d = bus.in_instr;
                        main_err_d   = x_err;
                        cnt_d        = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        // Old head leaves while the new entry takes its place.
                        main_imm_d   = x_imm;
                        main_instr_d = bus.in_instr;
                        main_err_d   = x_err;
                    end else if (push) begin
                        skid_imm_d   = x_imm;
                        skid_instr_d = bus.in_instr;
                        skid_err_d   = x_err;
                        cnt_d        = CNT_FULL;
                    end else if (pop) begin
                        cnt_d = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    // No push possible here: in_ready is low while full.
                    if (pop) begin
                        main_imm_d   = skid_imm_q;
                        main_instr_d = skid_instr_q;
                        main_err_d   = skid_err_q;
                        cnt_d        = CNT_ONE;
                    end
                end
                default: cnt_d = CNT_EMPTY;
            endcase
        end
        in_ready_d = (cnt_d != CNT_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= CNT_EMPTY;
            in_ready_q   <= 1'b1;
            main_imm_q   <= '0;
            main_instr_q <= '0;
            main_err_q   <= 1'b0;
            skid_imm_q   <= '0;
            skid_instr_q <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            main_imm_q   <= main_imm_d;
            main_instr_q <= main_instr_d;
            main_err_q   <= main_err_d;
            skid_imm_q   <= skid_imm_d;
            skid_instr_q <= skid_instr_d;
            skid_err_q   <= skid_err_d;
        end
    end

    // in_ready is forced low for the whole time reset is held.
    assign bus.in_ready  = in_ready_q & ~rst;
    assign bus.out_valid = (cnt_q != CNT_EMPTY);
    assign bus.out_imm   = main_imm_q;
    assign bus.out_instr = main_instr_q;
    assign bus.out_err   = main_err_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
    import scu_imm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .ILEN(32)) ifa ();
    imm_gen_stage_if #(.XLEN(64), .ILEN(32)) ifb ();

    imm_gen_stage #(.XLEN(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    imm_gen_stage #(.XLEN(64)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    // Immediate field at [21:10], with noise above and below it.
    function automatic logic [31:0] mk(input logic [11:0] f);
        return {10'h2A5, f, 10'h15A};
    endfunction

    task automatic drive_a(input logic v, input logic [11:0] f, input logic [1:0] fmt, input logic z);
        ifa.in_valid = v;
        ifa.in_instr = mk(f);
        ifa.in_fmt   = fmt;
        ifa.in_zext  = z;
    endtask

    // Present one input for one edge, return at the next falling edge.
    task automatic present_a(input logic [11:0] f, input logic [1:0] fmt, input logic z);
        @(negedge clk);
        drive_a(1'b1, f, fmt, z);
        @(negedge clk);
        ifa.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.out_imm !== 32'h0 ||
            ifa.out_instr !== 32'h0 || ifa.out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: valid=%b ready=%b imm=%h instr=%h err=%b required 0 0 0 0 0",
                     ifa.out_valid, ifa.in_ready, ifa.out_imm, ifa.out_instr, ifa.out_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b valid=%b required ready=1 valid=0", ifa.in_ready, ifa.out_valid);
        end
        $display("reset: checked");
    endtask

    task automatic test_short();
        logic [11:0] f [3] = '{12'h020, 12'h020, 12'hFDF};
        logic        z [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] e [3] = '{32'hFFFFFFE0, 32'h00000020, 32'h0000001F};
        for (int i = 0; i < 3; i++) begin
            present_a(f[i], FMT_SHORT, z[i]);
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.out_imm !== e[i] || ifa.out_err !== 1'b0 || ifa.out_instr !== mk(f[i])) begin
                bad++;
                $display("FAIL short[%0d]: valid=%b imm=%h err=%b instr=%h required 1 %h 0 %h",
                         i, ifa.out_valid, ifa.out_imm, ifa.out_err, ifa.out_instr, e[i], mk(f[i]));
            end
            $display("short[%0d]: field=%h zext=%b imm=%h", i, f[i], z[i], ifa.out_imm);
        end
    endtask

    task automatic test_long();
        logic [11:0] f [3] = '{12'h800, 12'h800, 12'h7FF};
        logic        z [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] e [3] = '{32'hFFFFF800, 32'h00000800, 32'h000007FF};
        for (int i = 0; i < 3; i++) begin
            present_a(f[i], FMT_LONG, z[i]);
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.out_imm !== e[i] || ifa.out_err !== 1'b0 || ifa.out_instr !== mk(f[i])) begin
                bad++;
                $display("FAIL long[%0d]: valid=%b imm=%h err=%b instr=%h required 1 %h 0 %h",
                         i, ifa.out_valid, ifa.out_imm, ifa.out_err, ifa.out_instr, e[i], mk(f[i]));
            end
            $display("long[%0d]: field=%h zext=%b imm=%h", i, f[i], z[i], ifa.out_imm);
        end
    endtask

    task automatic test_upper();
        logic [11:0] f [3] = '{12'hABC, 12'hABC, 12'h800};
        logic        z [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] e [3] = '{32'hABC00000, 32'hABC00000, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            present_a(f[i], FMT_UPPER, z[i]);
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.out_imm !== e[i] || ifa.out_err !== 1'b0) begin
                bad++;
                $display("FAIL upper[%0d]: valid=%b imm=%h err=%b required 1 %h 0",
                         i, ifa.out_valid, ifa.out_imm, ifa.out_err, e[i]);
            end
            $display("upper[%0d]: field=%h zext=%b imm=%h", i, f[i], z[i], ifa.out_imm);
        end
    endtask

    task automatic test_rsvd();
        present_a(12'hABC, FMT_RSVD, 1'b0);
        total++;
        if (ifa.out_valid !== 1'b1 || ifa.out_imm !== 32'h0 || ifa.out_err !== 1'b1 || ifa.out_instr !== mk(12'hABC)) begin
            bad++;
            $display("FAIL rsvd: valid=%b imm=%h err=%b instr=%h required 1 0 1 %h",
                     ifa.out_valid, ifa.out_imm, ifa.out_err, ifa.out_instr, mk(12'hABC));
        end
        $display("rsvd: imm=%h err=%b", ifa.out_imm, ifa.out_err);
        @(negedge clk);
        total++;
        if (ifa.out_valid !== 1'b0 || ifa.out_err !== 1'b1 || ifa.out_instr !== mk(12'hABC)) begin
            bad++;
            $display("FAIL rsvd_hold: valid=%b err=%b instr=%h required 0 1 %h",
                     ifa.out_valid, ifa.out_err, ifa.out_instr, mk(12'hABC));
        end
    endtask

    // Full-rate stream: each accepted entry replaces the previous one at count 1.
    task automatic test_back_to_back();
        logic [11:0] f [3] = '{12'h111, 12'h222, 12'h333};
        @(negedge clk);
        ifa.out_ready = 1'b1;
        drive_a(1'b1, f[0], FMT_LONG, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ifa.out_valid !== 1'b1 || ifa.out_imm !== {20'h0, f[i]} || ifa.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b[%0d]: valid=%b imm=%h ready=%b required 1 %h 1",
                         i, ifa.out_valid, ifa.out_imm, ifa.in_ready, {20'h0, f[i]});
            end
            $display("b2b[%0d]: imm=%h", i, ifa.out_imm);
            if (i < 2) drive_a(1'b1, f[i+1], FMT_LONG, 1'b1);
            else ifa.in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [11:0] f [4] = '{12'h101, 12'h202, 12'h303, 12'h404};
        logic [31:0] rcv [$];
        int accepted = 0;
        for (int cyc = 0; cyc < 30 && rcv.size() < 4; cyc++) begin
            @(negedge clk);
            if (cyc >= 1 && cyc <= 3) begin
                total++;
                if (ifa.out_valid !== 1'b1 || ifa.out_imm !== 32'h101) begin
                    bad++;
                    $display("FAIL bp_stall[%0d]: valid=%b imm=%h required 1 00000101", cyc, ifa.out_valid, ifa.out_imm);
                end
            end
            if (cyc == 3) begin
                total++;
                if (accepted != 2 || ifa.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_full: accepted=%0d ready=%b required 2 0", accepted, ifa.in_ready);
                end
            end
            ifa.out_ready = (cyc >= 3);
            if (accepted < 4) drive_a(1'b1, f[accepted], FMT_LONG, 1'b1);
            else ifa.in_valid = 1'b0;
            if (ifa.out_valid && ifa.out_ready) rcv.push_back(ifa.out_imm);
            if (ifa.in_valid && ifa.in_ready) accepted++;
        end
        ifa.in_valid = 1'b0;
        total++;
        if (rcv.size() != 4) begin
            bad++;
            $display("FAIL bp_count: received=%0d required 4", rcv.size());
        end
        for (int i = 0; i < rcv.size() && i < 4; i++) begin
            total++;
            if (rcv[i] !== {20'h0, f[i]}) begin
                bad++;
                $display("FAIL bp_order[%0d]: imm=%h required %h", i, rcv[i], {20'h0, f[i]});
            end
            $display("bp[%0d]: imm=%h", i, rcv[i]);
        end
        @(negedge clk);
        total++;
        if (ifa.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: valid=%b required 0", ifa.out_valid);
        end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        @(negedge clk);
        ifa.out_ready = 1'b0;
        drive_a(1'b1, 12'h0A1, FMT_LONG, 1'b1);
        @(negedge clk);
        drive_a(1'b1, 12'h0A2, FMT_LONG, 1'b1);
        @(negedge clk);
        total++;
        if (ifa.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_prefill: ready=%b required 0", ifa.in_ready);
        end
        ifa.flush = 1'b1;
        drive_a(1'b1, 12'h0A3, FMT_LONG, 1'b1);
        @(negedge clk);
        ifa.flush    = 1'b0;
        ifa.in_valid = 1'b0;
        total++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.out_imm !== 32'h0A1) begin
            bad++;
            $display("FAIL flush_full: valid=%b ready=%b imm=%h required 0 1 000000a1",
                     ifa.out_valid, ifa.in_ready, ifa.out_imm);
        end
        $display("flush full: valid=%b ready=%b", ifa.out_valid, ifa.in_ready);
        ifa.out_ready = 1'b1;
        // Flush at count 1 with a live accept: the flush must win.
        drive_a(1'b1, 12'h0B1, FMT_LONG, 1'b1);
        @(negedge clk);
        ifa.out_ready = 1'b0;
        ifa.flush = 1'b1;
        drive_a(1'b1, 12'h0B2, FMT_LONG, 1'b1);
        @(negedge clk);
        ifa.flush    = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (ifa.out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0 || ifa.out_imm !== 32'h0B1) begin
            bad++;
            $display("FAIL flush_one: stray_valid=%b imm=%h required 0 000000b1", seen, ifa.out_imm);
        end
        $display("flush one: stray_valid=%b", seen);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        ifa.out_ready = 1'b0;
        drive_a(1'b1, 12'h0C1, FMT_SHORT, 1'b0);
        @(negedge clk);
        drive_a(1'b1, 12'h0C2, FMT_RSVD, 1'b0);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.out_imm !== 32'h0 ||
            ifa.out_instr !== 32'h0 || ifa.out_err !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: valid=%b ready=%b imm=%h instr=%h err=%b required 0 0 0 0 0",
                     ifa.out_valid, ifa.in_ready, ifa.out_imm, ifa.out_instr, ifa.out_err);
        end
        @(negedge clk);
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        #1;
        total++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_release: valid=%b ready=%b required 0 1", ifa.out_valid, ifa.in_ready);
        end
        $display("async reset: checked");
    endtask

    task automatic test_xlen64();
        @(negedge clk);
        ifb.in_valid = 1'b1;
        ifb.in_instr = mk(12'h800);
        ifb.in_fmt   = FMT_LONG;
        ifb.in_zext  = 1'b0;
        @(negedge clk);
        ifb.in_instr = mk(12'hABC);
        ifb.in_fmt   = FMT_UPPER;
        ifb.in_zext  = 1'b1;
        total++;
        if (ifb.out_valid !== 1'b1 || ifb.out_imm !== 64'hFFFFFFFFFFFFF800) begin
            bad++;
            $display("FAIL x64_long: valid=%b imm=%h required 1 fffffffffffff800", ifb.out_valid, ifb.out_imm);
        end
        $display("x64 long: imm=%h", ifb.out_imm);
        @(negedge clk);
        ifb.in_valid = 1'b0;
        total++;
        if (ifb.out_valid !== 1'b1 || ifb.out_imm !== 64'hABC0000000000000 || ifb.out_err !== 1'b0) begin
            bad++;
            $display("FAIL x64_upper: valid=%b imm=%h err=%b required 1 abc0000000000000 0",
                     ifb.out_valid, ifb.out_imm, ifb.out_err);
        end
        $display("x64 upper: imm=%h", ifb.out_imm);
    endtask

    initial begin
        ifa.flush = 1'b0; ifa.out_ready = 1'b1;
        drive_a(1'b0, 12'h0, FMT_SHORT, 1'b0);
        ifb.flush = 1'b0; ifb.out_ready = 1'b1; ifb.in_valid = 1'b0;
        ifb.in_instr = '0; ifb.in_fmt = FMT_SHORT; ifb.in_zext = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_upper();
        test_rsvd();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_xlen64();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
